clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Front-panel controller for the millennium clock.
- Turns three debounced key pulses into:
  - the display view select;
  - the per-field blink controls for the 8-digit seven-segment display block;
  - increment pulses to the time/date counters;
  - a run-enable that freezes timekeeping while time fields are edited.
- Sits between the key debouncers and the counter/display blocks; sequences field editing with an inactivity timeout.

Parameters:
- TIMEOUT_S, 10: seconds of key inactivity in an edit state before automatic return to RUN. 0 disables the timeout.
- TW, 4: timeout counter width. Must satisfy 2^TW > TIMEOUT_S.

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  synchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse per second from the prescaler.
- key_mode  in  1  one-cycle debounced pulse: toggle view.
- key_select  in  1  one-cycle debounced pulse: enter edit / advance field.
- key_inc  in  1  one-cycle debounced pulse: increment selected field.
- mode_display  out  1  1 = time view, 0 = date view.
- blink_hour_day  out  1  blink hour (time view) or day (date view) digits.
- blink_minute_month  out  1  blink minute or month digits.
- blink_second_year  out  1  blink second or year digits.
- inc_hour, inc_minute, inc_second  out  1 each  one-cycle increment pulses to the time counters.
- inc_day, inc_month, inc_year  out  1 each  one-cycle increment pulses to the date counters.
- clr_second  out  1  one-cycle seconds-clear pulse (see Optional Feature).
- run_en  out  1  1 = timekeeping counters advance on tick_1hz.

Behaviour:
- Clock: all state on posedge clk. rst_n is sampled synchronously and active-low; reset overrides all inputs in the same edge.
- Reset values:
  - state = RUN, mode_display = 1, run_en = 1, timeout counter = 0;
  - all blink, inc_* and clr_second outputs = 0.
- All outputs are registered. Response appears exactly 1 cycle after the key pulse is sampled.
- FSM states: RUN, EDIT_HI, EDIT_MID, EDIT_LO.
- RUN:
  - key_select -> EDIT_HI.
  - key_mode (with no key_select) -> toggle mode_display.
  - key_inc is ignored.
  - If key_mode and key_select arrive together, key_select wins and key_mode is dropped.
- EDIT_HI:
  - key_select -> EDIT_MID.
  - key_inc -> inc_hour (time view) or inc_day (date view).
- EDIT_MID:
  - key_select -> EDIT_LO.
  - key_inc -> inc_minute or inc_month.
- EDIT_LO:
  - key_select -> RUN.
  - key_inc -> inc_second or inc_year.
- In all edit states:
  - key_mode is ignored; the view is locked during edit.
  - If key_select and key_inc arrive together, key_select wins: the state advances and no inc pulse is issued.
- Blink outputs: exactly one blink output is high per edit state (HI -> blink_hour_day, MID -> blink_minute_month, LO -> blink_second_year). All are 0 in RUN.
- run_en:
  - 0 in any edit state while mode_display = 1.
  - 1 in RUN.
  - 1 during date-view edit, so the clock keeps running.
- inc_* pulses are exactly 1 cycle wide, one per key_inc, never more than one asserted per cycle. Counter-side wrap (e.g. hour 23 -> 00) is the counter's responsibility.
- Timeout counter:
  - Increments on tick_1hz only in edit states.
  - Cleared on any key_select, key_inc or key_mode in an edit state, and on entry to RUN.
  - If a key and tick_1hz arrive in the same cycle, the key wins (counter cleared).
  - When counter == TIMEOUT_S (TIMEOUT_S != 0): next state = RUN, with no inc pulse that cycle.
  - The counter saturates and never wraps.
- Reset mid-edit: returns to RUN, pending inc is not emitted, mode_display returns to 1.

Optional Feature:
- Macro: SECONDS_ZERO_EN.
- Defined: in EDIT_LO with time view, key_inc issues a clr_second pulse (1 cycle) instead of inc_second. Matches wristwatch seconds-zeroing.
- Undefined: clr_second is tied to 0 and EDIT_LO/time behaves as inc_second.
- The port is present in both builds.

Test Plan:
- Reset -> key_select -> key_inc x3 (1-cycle pulses, 4 cycles apart): state EDIT_HI, blink_hour_day = 1, run_en = 0, exactly 3 single-cycle inc_hour pulses, each 1 cycle after its key.
- key_mode in RUN, then key_select x2, key_inc: mode_display = 0, blink_minute_month = 1, run_en stays 1, one inc_month pulse, no inc_minute.
- key_select and key_inc asserted in the same cycle in EDIT_MID: state becomes EDIT_LO, no inc pulse. Then key_mode in EDIT_LO: mode_display unchanged.
- TIMEOUT_S = 3: enter EDIT_HI, apply 3 tick_1hz with no keys: returns to RUN 1 cycle after the 3rd tick, all blinks 0, run_en = 1. Repeat with key_inc on the 2nd tick cycle: no timeout until 3 further ticks.
- Assert rst_n = 0 for one clock in EDIT_LO while key_inc is high: next cycle state RUN, mode_display = 1, no inc/clr pulse. rst_n deasserted between edges has no effect.
- SECONDS_ZERO_EN defined, time view EDIT_LO, key_inc: clr_second = 1 for 1 cycle, inc_second = 0. Undefined build: inc_second = 1, clr_second = 0.

Source files
------------

// File: rtl/clock_set_controller_if.sv
// Key-pulse inputs and panel outputs of the clock front-panel controller.
// The controller uses the slave modport; the key/prescaler side uses master.
interface clock_set_controller_if;
  logic tick_1hz;
  logic key_mode;
  logic key_select;
  logic key_inc;
  logic mode_display;
  logic blink_hour_day;
  logic blink_minute_month;
  logic blink_second_year;
  logic inc_hour;
  logic inc_minute;
  logic inc_second;
  logic inc_day;
  logic inc_month;
  logic inc_year;
  logic clr_second;
  logic run_en;

  modport master (
    output tick_1hz, key_mode, key_select, key_inc,
    input  mode_display, blink_hour_day, blink_minute_month, blink_second_year,
    input  inc_hour, inc_minute, inc_second, inc_day, inc_month, inc_year,
    input  clr_second, run_en
  );

  modport slave (
    input  tick_1hz, key_mode, key_select, key_inc,
    output mode_display, blink_hour_day, blink_minute_month, blink_second_year,
    output inc_hour, inc_minute, inc_second, inc_day, inc_month, inc_year,
    output clr_second, run_en
  );
endinterface

// File: rtl/clock_set_controller.sv
// Front-panel edit sequencer for the millennium clock: view select, field blink,
// increment pulses, run-enable and inactivity timeout. Optional macro SECONDS_ZERO_EN.
//
// state        | meaning
// ST_RUN       | normal timekeeping, key_mode toggles view
// ST_EDIT_HI   | editing hour (time view) or day (date view)
// ST_EDIT_MID  | editing minute or month
// ST_EDIT_LO   | editing second or year
module clock_set_controller #(
  parameter int TIMEOUT_S = 10,
  parameter int TW        = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  clock_set_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EDIT_HI  = 2'd1,
    ST_EDIT_MID = 2'd2,
    ST_EDIT_LO  = 2'd3
  } state_e;

  localparam logic [TW-1:0] TMR_MAX   = '1;
  localparam logic [TW-1:0] TMR_LIMIT = TW'(TIMEOUT_S);
  localparam logic          TO_ENABLE = (TIMEOUT_S != 0);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    blink_q, blink_d;   // [0] hour/day, [1] minute/month, [2] second/year
  logic [5:0]    inc_q, inc_d;       // [5:3] hour/minute/second, [2:0] day/month/year
  logic          clr_q, clr_d;
  logic          run_en_q, run_en_d;

  logic in_edit;
  logic any_key;
  logic timed_out;
  logic inc_req;

  assign in_edit   = (state_q != ST_RUN);
  assign any_key   = bus.key_select | bus.key_inc | bus.key_mode;
  assign timed_out = TO_ENABLE && in_edit && (tmr_q == TMR_LIMIT);
  // select beats inc, and a timeout swallows any pending increment
  assign inc_req   = in_edit && bus.key_inc && !bus.key_select && !timed_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      mode_q   <= 1'b1;
      tmr_q    <= '0;
      blink_q  <= '0;
      inc_q    <= '0;
      clr_q    <= 1'b0;
      run_en_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      tmr_q    <= tmr_d;
      blink_q  <= blink_d;
      inc_q    <= inc_d;
      clr_q    <= clr_d;
      run_en_q <= run_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_RUN: begin
        if (bus.key_select) begin
          state_d = ST_EDIT_HI;
        end else if (bus.key_mode) begin
          mode_d = !mode_q;
        end
      end
      ST_EDIT_HI:  if (bus.key_select) state_d = ST_EDIT_MID;
      ST_EDIT_MID: if (bus.key_select) state_d = ST_EDIT_LO;
      ST_EDIT_LO:  if (bus.key_select) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    // keys beat a coincident tick; the counter holds at its maximum
    if (in_edit) begin
      if (any_key) begin
        tmr_d = '0;
      end else if (bus.tick_1hz && (tmr_q != TMR_MAX)) begin
        tmr_d = tmr_q + TW'(1);
      end
    end

    if (timed_out) begin
      state_d = ST_RUN;
    end
    if (state_d == ST_RUN) begin
      tmr_d = '0;
    end
  end

  always_comb begin
    blink_d  = 3'b000;
    inc_d    = 6'b000000;
    clr_d    = 1'b0;
    run_en_d = (state_d == ST_RUN) || !mode_d;

    case (state_d)
      ST_EDIT_HI:  blink_d = 3'b001;
      ST_EDIT_MID: blink_d = 3'b010;
      ST_EDIT_LO:  blink_d = 3'b100;
      default:     blink_d = 3'b000;
    endcase

    if (inc_req) begin
      case (state_q)
        ST_EDIT_HI:  inc_d = mode_q ? 6'b100000 : 6'b000100;
        ST_EDIT_MID: inc_d = mode_q ? 6'b010000 : 6'b000010;
        ST_EDIT_LO: begin
`ifdef SECONDS_ZERO_EN
          if (mode_q) begin
            clr_d = 1'b1;
          end else begin
            inc_d = 6'b000001;
          end
`else
          inc_d = mode_q ? 6'b001000 : 6'b000001;
`endif
        end
        default: inc_d = 6'b000000;
      endcase
    end
  end

  assign bus.mode_display       = mode_q;
  assign bus.blink_hour_day     = blink_q[0];
  assign bus.blink_minute_month = blink_q[1];
  assign bus.blink_second_year  = blink_q[2];
  assign bus.inc_hour           = inc_q[5];
  assign bus.inc_minute         = inc_q[4];
  assign bus.inc_second         = inc_q[3];
  assign bus.inc_day            = inc_q[2];
  assign bus.inc_month          = inc_q[1];
  assign bus.inc_year           = inc_q[0];
  assign bus.clr_second         = clr_q;
  assign bus.run_en             = run_en_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: field-level reference model checked every cycle,
// directed test-plan sequences with literal expectations, then random key traffic.
module tb_clock_set_controller;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_set_controller_if bus();

  clock_set_controller #(.TIMEOUT_S(TO), .TW(4)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errs = 0;
  int checks = 0;

  // model: field 0 = run, 1..3 = edited field; view 1 = time
  int         m_field = 0;
  int         m_timer = 0;
  bit         m_view = 1'b1;
  logic [11:0] exp_v;
  int         pulse_cnt [6];

  function automatic logic [11:0] dut_v();
    return {bus.mode_display, bus.blink_hour_day, bus.blink_minute_month,
            bus.blink_second_year, bus.inc_hour, bus.inc_minute, bus.inc_second,
            bus.inc_day, bus.inc_month, bus.inc_year, bus.clr_second, bus.run_en};
  endfunction

  task automatic model_step(input bit rst, input bit tick, input bit km,
                            input bit ks, input bit ki);
    int fire;
    bit clr;
    logic [5:0] inc;
    fire = 0;
    if (!rst) begin
      m_field = 0; m_view = 1'b1; m_timer = 0;
    end else if (m_field == 0) begin
      if (ks) m_field = 1;
      else if (km) m_view = !m_view;
      m_timer = 0;
    end else begin
      if (TO != 0 && m_timer == TO) begin
        m_field = 0;
      end else begin
        if (ks) m_field = (m_field + 1) % 4;
        else if (ki) fire = m_field;
        if (ks || ki || km) m_timer = 0;
        else if (tick && m_timer < 15) m_timer = m_timer + 1;
      end
      if (m_field == 0) m_timer = 0;
    end
    inc = '0;
    clr = 1'b0;
    if (fire != 0) begin
`ifdef SECONDS_ZERO_EN
      if (m_view && fire == 3) clr = 1'b1;
      else
`endif
      inc[(m_view ? 6 : 3) - fire] = 1'b1;
    end
    exp_v = {m_view, m_field == 1, m_field == 2, m_field == 3, inc, clr,
             (m_field == 0) || !m_view};
  endtask

  task automatic check_outputs();
    logic [11:0] got;
    got = dut_v();
    checks++;
    if (got !== exp_v) begin
      errs++;
      $display("FAIL outputs t=%0t got=%03h exp=%03h (mode,blk3,inc hms dmy,clr,run)",
               $time, got, exp_v);
    end
    pulse_cnt[0] += int'(bus.inc_hour);
    pulse_cnt[1] += int'(bus.inc_minute);
    pulse_cnt[2] += int'(bus.inc_second);
    pulse_cnt[3] += int'(bus.inc_day);
    pulse_cnt[4] += int'(bus.inc_month);
    pulse_cnt[5] += int'(bus.inc_year);
  endtask

  task automatic lit(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) pulse_cnt[i] = 0;
  endtask

  task automatic drive(input bit tick, input bit km, input bit ks, input bit ki);
    bus.tick_1hz   = tick;
    bus.key_mode   = km;
    bus.key_select = ks;
    bus.key_inc    = ki;
  endtask

  task automatic cyc(input bit rst, input bit tick, input bit km,
                     input bit ks, input bit ki);
    rst_n = rst;
    drive(tick, km, ks, ki);
    model_step(rst, tick, km, ks, ki);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  // rst_n pulses low strictly between edges; must not reset anything
  task automatic glitch_cycle();
    drive(0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    drive(0, 0, 0, 0);
    clear_counts();
    @(negedge clk);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1);
    lit("reset_mode", int'(bus.mode_display), 1);
    lit("reset_run_en", int'(bus.run_en), 1);

    // three increments of the hour field
    cyc(1, 0, 0, 1, 0);
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 1);
      lit("inc_hour_next_cycle", int'(bus.inc_hour), 1);
      idle(3);
    end
    lit("inc_hour_count", pulse_cnt[0], 3);
    lit("edit_hi_blink", int'(bus.blink_hour_day), 1);
    lit("edit_hi_run_en", int'(bus.run_en), 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);

    // date view, month edit
    cyc(1, 0, 1, 0, 0);
    lit("date_view", int'(bus.mode_display), 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    clear_counts();
    cyc(1, 0, 0, 0, 1);
    idle(1);
    lit("inc_month_count", pulse_cnt[4], 1);
    lit("inc_minute_count", pulse_cnt[1], 0);
    lit("date_edit_blink_mid", int'(bus.blink_minute_month), 1);
    lit("date_edit_run_en", int'(bus.run_en), 1);
    clear_counts();
    cyc(1, 0, 0, 1, 1);
    lit("sel_beats_inc_state", int'(bus.blink_second_year), 1);
    cyc(1, 0, 1, 0, 0);
    lit("mode_locked_in_edit", int'(bus.mode_display), 0);
    lit("sel_beats_inc_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] +
        pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5], 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);

    // timeout after three idle ticks
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0); idle(1);
    cyc(1, 1, 0, 0, 0); idle(1);
    cyc(1, 1, 0, 0, 0);
    lit("before_timeout_blink", int'(bus.blink_hour_day), 1);
    idle(1);
    lit("timeout_blink", int'(bus.blink_hour_day), 0);
    lit("timeout_run_en", int'(bus.run_en), 1);

    // a key on the second tick restarts the count
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 0); idle(1);
    cyc(1, 1, 0, 0, 0); idle(1);
    lit("restart_no_timeout", int'(bus.blink_hour_day), 1);
    cyc(1, 1, 0, 0, 0); idle(1);
    lit("restart_timeout", int'(bus.blink_hour_day), 0);

    // reset in date-view EDIT_LO with key_inc high
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    clear_counts();
    cyc(0, 0, 0, 0, 1);
    lit("rst_mode", int'(bus.mode_display), 1);
    lit("rst_blink_lo", int'(bus.blink_second_year), 0);
    lit("rst_no_pulse", pulse_cnt[5] + pulse_cnt[2] + int'(bus.clr_second), 0);

    // glitch on rst_n, then seconds field in time view
    cyc(1, 0, 0, 1, 0);
    glitch_cycle();
    lit("glitch_no_reset", int'(bus.blink_hour_day), 1);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1);
`ifdef SECONDS_ZERO_EN
    lit("lo_clr_second", int'(bus.clr_second), 1);
    lit("lo_inc_second", int'(bus.inc_second), 0);
`else
    lit("lo_clr_second", int'(bus.clr_second), 0);
    lit("lo_inc_second", int'(bus.inc_second), 1);
`endif
    cyc(1, 0, 0, 1, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
